// File: rtl/tdes_decrypt_seq.sv
// Sequential two-key Triple-DES decryptor: D(k1) . E(k2) . D(k1) over three passes of one
// shared combinational DES core, sequenced by a small FSM with a start/done handshake.
module tdes_decrypt_seq #(
    parameter int unsigned PASS_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [55:0] key1,
    input  logic [55:0] key2,
    input  logic [63:0] ciphertext,
    output logic [63:0] plaintext,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] LastWait = 4'(PASS_CYCLES - 1);

    localparam int Ip [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };
    localparam int PTab [32] = '{
        16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
        2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
    };
    localparam int Pc1 [56] = '{
        57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
        10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
        14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
    };
    localparam int Pc2 [48] = '{
        14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4,
        26, 8, 16, 7, 27, 20, 13, 2, 41, 52, 31, 37, 47, 55, 30, 40,
        51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    // Bit n set: key-schedule round n rotates by two instead of one.
    localparam logic [15:0] Shift2 = 16'h7EFC;
    // Row-major S-box entries, entry 0 in the top nibble.
    localparam logic [255:0] SBox [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Combinational DES core; enc=0 runs the subkeys in reverse order.
    function automatic logic [63:0] des_core(input logic [63:0] din, input logic [55:0] key,
                                             input logic enc);
        logic [63:0] k64, perm, pre, dout;
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] sub [16];
        logic [47:0] x;
        logic [31:0] l, r, sout, f, t;
        logic [5:0]  idx;
        int          src;
        for (int i = 0; i < 8; i++) k64[63-8*i -: 8] = {key[55-7*i -: 7], 1'b0};
        for (int i = 0; i < 56; i++) cd[55-i] = k64[64-Pc1[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            if (Shift2[n]) begin
                c = {c[25:0], c[27:26]};
                d = {d[25:0], d[27:26]};
            end else begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) sub[n][47-i] = cd[56-Pc2[i]];
        end
        for (int i = 0; i < 64; i++) perm[63-i] = din[64-Ip[i]];
        l = perm[63:32];
        r = perm[31:0];
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < 8; j++) begin
                for (int k = 0; k < 6; k++) begin
                    src = 4 * j + k;
                    if (src == 0) src = 32;
                    else if (src == 33) src = 1;
                    x[47-(6*j+k)] = r[32-src];
                end
            end
            x = x ^ (enc ? sub[n] : sub[15-n]);
            for (int j = 0; j < 8; j++) begin
                idx = {x[47-6*j], x[42-6*j], x[46-6*j -: 4]};
                sout[31-4*j -: 4] = SBox[j][255-4*int'(idx) -: 4];
            end
            for (int i = 0; i < 32; i++) f[31-i] = sout[32-PTab[i]];
            t = l ^ f;
            l = r;
            r = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) dout[64-Ip[i]] = pre[63-i];
        return dout;
    endfunction

    typedef enum logic [1:0] {StIdle, StPass, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [3:0]  wait_q, wait_d;
    logic [63:0] data_q, data_d;
    logic [63:0] pt_q, pt_d;
    logic [55:0] k1_q, k1_d, k2_q, k2_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [55:0] des_key;
    logic        des_enc;
    logic [63:0] des_out;

    // The single shared core: only the middle pass encrypts, with key2.
    always_comb begin
        des_enc = (pass_q == 2'd1);
        des_key = des_enc ? k2_q : k1_q;
        des_out = des_core(data_q, des_key, des_enc);
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        wait_d  = wait_q;
        data_d  = data_q;
        pt_d    = pt_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    data_d  = ciphertext;
                    k1_d    = key1;
                    k2_d    = key2;
                    pass_d  = 2'd0;
                    wait_d  = 4'd0;
                    busy_d  = 1'b1;
                    state_d = StPass;
                end
            end
            StPass: begin
                wait_d = wait_q + 4'd1;
                if (wait_q == LastWait) begin
                    data_d = des_out;
                    wait_d = 4'd0;
                    pass_d = pass_q + 2'd1;
                    if (pass_q == 2'd2) begin
                        pt_d    = des_out;
                        pass_d  = 2'd0;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pass_q  <= 2'd0;
            wait_q  <= 4'd0;
            data_q  <= 64'd0;
            pt_q    <= 64'd0;
            k1_q    <= 56'd0;
            k2_q    <= 56'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            pt_q    <= pt_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign plaintext = pt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
